// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one 32-bit BRAM port between two
// requesters. One access at a time; read latency is absorbed by a wait counter.
`default_nettype none

module bram_port_arbiter #(
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        r0_valid,
    input  logic [3:0]  r0_we,
    input  logic [14:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_done,
    input  logic        r1_valid,
    input  logic [3:0]  r1_we,
    input  logic [14:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_done,
    output logic [31:0] rsp_rdata,
    output logic        grant_id,
    output logic        busy,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [14:0] bram_addr,
    output logic [31:0] bram_wdata,
    input  logic [31:0] bram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_id_q, grant_id_d;
    logic        busy_q, busy_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        bram_en_q, bram_en_d;
    logic [3:0]  bram_we_q, bram_we_d;
    logic [14:0] bram_addr_q, bram_addr_d;
    logic [31:0] bram_wdata_q, bram_wdata_d;
    logic        win;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        bram_en_d    = bram_en_q;
        bram_we_d    = bram_we_q;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        // On a tie the requester that did not win last time goes first
        win          = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;

        case (state_q)
            ST_IDLE: begin
                if (r0_valid || r1_valid) begin
                    bram_en_d    = 1'b1;
                    bram_we_d    = win ? r1_we    : r0_we;
                    bram_addr_d  = win ? r1_addr  : r0_addr;
                    bram_wdata_d = win ? r1_wdata : r0_wdata;
                    grant_id_d   = win;
                    last_grant_d = win;
                    count_d      = 4'(READ_LAT - 1);
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    rsp_rdata_d = bram_rdata;
                    done0_d     = ~grant_id_q;
                    done1_d     = grant_id_q;
                    bram_en_d   = 1'b0;
                    bram_we_d   = 4'd0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            count_q      <= 4'd0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            busy_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 4'd0;
            bram_addr_q  <= 15'd0;
            bram_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rsp_rdata_q  <= rsp_rdata_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
        end
    end

    assign r0_done    = done0_q;
    assign r1_done    = done1_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign bram_en    = bram_en_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: two arbiter instances (READ_LAT=2 and READ_LAT=1), each with a
// BRAM model, checked against an access-level timeline and a word-array memory model.
`default_nettype none

module tb_bram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;

    // "a" instance: READ_LAT=2, "b" instance: READ_LAT=1
    logic [1:0]  a_valid, b_valid, a_done, b_done;
    logic [3:0]  a_we [2];
    logic [3:0]  b_we [2];
    logic [14:0] a_ad [2];
    logic [14:0] b_ad [2];
    logic [31:0] a_wd [2];
    logic [31:0] b_wd [2];
    logic [31:0] a_rsp, b_rsp, a_bwd, b_bwd, a_brd, b_brd;
    logic        a_gid, b_gid, a_busy, b_busy, a_en, b_en;
    logic [3:0]  a_bwe, b_bwe;
    logic [14:0] a_baddr, b_baddr;

    bram_port_arbiter #(.READ_LAT(2)) u_dut_a (
        .clk(clk), .resetn(resetn),
        .r0_valid(a_valid[0]), .r0_we(a_we[0]), .r0_addr(a_ad[0]), .r0_wdata(a_wd[0]), .r0_done(a_done[0]),
        .r1_valid(a_valid[1]), .r1_we(a_we[1]), .r1_addr(a_ad[1]), .r1_wdata(a_wd[1]), .r1_done(a_done[1]),
        .rsp_rdata(a_rsp), .grant_id(a_gid), .busy(a_busy),
        .bram_en(a_en), .bram_we(a_bwe), .bram_addr(a_baddr), .bram_wdata(a_bwd), .bram_rdata(a_brd)
    );

    bram_port_arbiter #(.READ_LAT(1)) u_dut_b (
        .clk(clk), .resetn(resetn),
        .r0_valid(b_valid[0]), .r0_we(b_we[0]), .r0_addr(b_ad[0]), .r0_wdata(b_wd[0]), .r0_done(b_done[0]),
        .r1_valid(b_valid[1]), .r1_we(b_we[1]), .r1_addr(b_ad[1]), .r1_wdata(b_wd[1]), .r1_done(b_done[1]),
        .rsp_rdata(b_rsp), .grant_id(b_gid), .busy(b_busy),
        .bram_en(b_en), .bram_we(b_bwe), .bram_addr(b_baddr), .bram_wdata(b_bwd), .bram_rdata(b_brd)
    );

    // BRAM models: "a" has one registered read stage, "b" reads combinationally
    bit [31:0] mem_a [0:32767];
    bit [31:0] mem_b [0:32767];

    always @(posedge clk) begin
        if (!resetn) begin
            mem_a[0] <= 32'h0000_0005;
        end else if (a_en) begin
            for (int i = 0; i < 4; i++)
                if (a_bwe[i]) mem_a[a_baddr][8*i +: 8] <= a_bwd[8*i +: 8];
            a_brd <= mem_a[a_baddr];
        end
    end

    assign b_brd = mem_b[b_baddr];
    always @(posedge clk) begin
        if (!resetn) begin
            mem_b[3] <= 32'hCAFE_F00D;
        end else if (b_en) begin
            for (int i = 0; i < 4; i++)
                if (b_bwe[i]) mem_b[b_baddr][8*i +: 8] <= b_bwd[8*i +: 8];
        end
    end

    // Reference state: expected memory contents and round-robin pointer per instance
    bit [31:0] ref_mem [0:1][0:32767];
    bit        last_g [0:1];
    int        n_vec = 0;
    int        n_err = 0;
    bit        cur_sel = 1'b0;

    logic [1:0]  o_done;
    logic [31:0] o_rsp, o_bwd;
    logic        o_gid, o_busy, o_en;
    logic [3:0]  o_bwe;
    logic [14:0] o_baddr;
    assign o_done  = cur_sel ? b_done  : a_done;
    assign o_rsp   = cur_sel ? b_rsp   : a_rsp;
    assign o_bwd   = cur_sel ? b_bwd   : a_bwd;
    assign o_gid   = cur_sel ? b_gid   : a_gid;
    assign o_busy  = cur_sel ? b_busy  : a_busy;
    assign o_en    = cur_sel ? b_en    : a_en;
    assign o_bwe   = cur_sel ? b_bwe   : a_bwe;
    assign o_baddr = cur_sel ? b_baddr : a_baddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " done"},  32'(o_done),  32'd0);
        chk({tag, " rsp"},   o_rsp,        32'd0);
        chk({tag, " gid"},   32'(o_gid),   32'd0);
        chk({tag, " busy"},  32'(o_busy),  32'd0);
        chk({tag, " en"},    32'(o_en),    32'd0);
        chk({tag, " we"},    32'(o_bwe),   32'd0);
        chk({tag, " addr"},  32'(o_baddr), 32'd0);
        chk({tag, " wdata"}, o_bwd,        32'd0);
    endtask

    task automatic drive(input bit sel, input int r, input logic v, input logic [3:0] we,
                         input logic [14:0] ad, input logic [31:0] d);
        if (sel) begin
            b_valid[r] = v; b_we[r] = we; b_ad[r] = ad; b_wd[r] = d;
        end else begin
            a_valid[r] = v; a_we[r] = we; a_ad[r] = ad; a_wd[r] = d;
        end
    endtask

    // One access, presented at a negedge while idle. Expected timeline relative to
    // the grant edge E0: BRAM enabled for READ_LAT cycles, done one cycle after
    // capture, idle again one cycle later so the next grant can happen on the next edge.
    task automatic access(input bit sel, input logic [1:0] v,
                          input logic [3:0] we0, input logic [3:0] we1,
                          input logic [14:0] ad0, input logic [14:0] ad1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          output bit win, output logic [31:0] rd);
        int          rl;
        logic [3:0]  ewe;
        logic [14:0] ead;
        logic [31:0] ewd, erd;
        rl      = sel ? 1 : 2;
        cur_sel = sel;
        drive(sel, 0, v[0], we0, ad0, d0);
        drive(sel, 1, v[1], we1, ad1, d1);
        #1;
        chk("pre busy", 32'(o_busy), 32'd0);
        chk("pre en",   32'(o_en),   32'd0);
        win = (v == 2'b11) ? ~last_g[sel] : v[1];
        last_g[sel] = win;
        ewe = win ? we1 : we0;
        ead = win ? ad1 : ad0;
        ewd = win ? d1  : d0;
        erd = ref_mem[sel][ead];
        for (int i = 0; i < 4; i++)
            if (ewe[i]) ref_mem[sel][ead][8*i +: 8] = ewd[8*i +: 8];
        rd = 32'd0;
        for (int k = 0; k <= rl + 1; k++) begin
            @(negedge clk);
            chk($sformatf("en k%0d", k),    32'(o_en),   32'(k < rl));
            chk($sformatf("we k%0d", k),    32'(o_bwe),  (k < rl) ? 32'(ewe) : 32'd0);
            chk($sformatf("addr k%0d", k),  32'(o_baddr), 32'(ead));
            chk($sformatf("wdata k%0d", k), o_bwd,        ewd);
            chk($sformatf("gid k%0d", k),   32'(o_gid),  32'(win));
            chk($sformatf("busy k%0d", k),  32'(o_busy), 32'(k <= rl));
            chk($sformatf("done0 k%0d", k), 32'(o_done[0]), 32'(k == rl && !win));
            chk($sformatf("done1 k%0d", k), 32'(o_done[1]), 32'(k == rl && win));
            if (k == rl) begin
                rd = o_rsp;
                if (ewe == 4'd0) chk("rsp_rdata", o_rsp, erd);
                if (sel) b_valid[win] = 1'b0;
                else     a_valid[win] = 1'b0;
            end
        end
    endtask

    // Randomised traffic; a losing requester keeps its request stable until served
    task automatic rand_run(input bit sel, input int n);
        logic [1:0]  pv;
        logic [3:0]  pwe [2];
        logic [14:0] pad [2];
        logic [31:0] pwd [2];
        bit          w;
        logic [31:0] rd;
        pv = 2'b00;
        for (int it = 0; it < n; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && ($urandom_range(0, 2) != 0 || (r == 1 && pv == 2'b00))) begin
                    pv[r]  = 1'b1;
                    pwe[r] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                    pad[r] = 15'($urandom_range(1, 15));
                    pwd[r] = $urandom;
                end
            end
            access(sel, pv, pwe[0], pwe[1], pad[0], pad[1], pwd[0], pwd[1], w, rd);
            pv[w] = 1'b0;
        end
        if (sel) b_valid = 2'b00;
        else     a_valid = 2'b00;
    endtask

    initial begin
        bit          w;
        logic [31:0] rd;
        resetn  = 1'b0;
        a_valid = 2'b00;
        b_valid = 2'b00;
        for (int r = 0; r < 2; r++) begin
            drive(1'b0, r, 1'b0, 4'h0, 15'h0, 32'h0);
            drive(1'b1, r, 1'b0, 4'h0, 15'h0, 32'h0);
        end
        last_g[0] = 1'b1;
        last_g[1] = 1'b1;
        ref_mem[0][0] = 32'h0000_0005;
        ref_mem[1][3] = 32'hCAFE_F00D;

        repeat (2) @(negedge clk);
        cur_sel = 1'b0; #1; chk_zero("reset a");
        cur_sel = 1'b1; #1; chk_zero("reset b");
        @(negedge clk);
        resetn = 1'b1;

        // Contention: both hold valid; grants alternate starting with r0
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 2'b11, 4'h0, 4'h0, 15'h1, 15'h2, 32'h0, 32'h0, w, rd);
            chk($sformatf("cont grant %0d", i), 32'(w), 32'(i % 2));
        end
        a_valid = 2'b00;

        access(1'b0, 2'b01, 4'h0, 4'h0, 15'h0, 15'h0, 32'h0, 32'h0, w, rd);
        chk("single read", rd, 32'h0000_0005);

        access(1'b0, 2'b10, 4'h0, 4'hF, 15'h0, 15'h8, 32'h0, 32'h0000_000C, w, rd);
        access(1'b0, 2'b10, 4'h0, 4'h0, 15'h0, 15'h8, 32'h0, 32'h0, w, rd);
        chk("write then read", rd, 32'h0000_000C);

        access(1'b0, 2'b01, 4'b0011, 4'h0, 15'h4, 15'h0, 32'hAABB_CCDD, 32'h0, w, rd);
        access(1'b0, 2'b01, 4'h0, 4'h0, 15'h4, 15'h0, 32'h0, 32'h0, w, rd);
        chk("byte write read", rd, 32'h0000_CCDD);

        rand_run(1'b0, 40);

        // Reset during WAIT of a write
        cur_sel = 1'b0;
        drive(1'b0, 0, 1'b1, 4'hF, 15'h7FFF, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        chk("midrst pre en",   32'(a_en),   32'd1);
        chk("midrst pre busy", 32'(a_busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk_zero("midrst async");
        a_valid = 2'b00;
        repeat (2) begin
            @(negedge clk);
            chk("midrst no done", 32'(a_done), 32'd0);
        end
        resetn    = 1'b1;
        last_g[0] = 1'b1;
        last_g[1] = 1'b1;
        access(1'b0, 2'b11, 4'h0, 4'h0, 15'h5, 15'h6, 32'h0, 32'h0, w, rd);
        chk("post reset tie", 32'(w), 32'd0);
        a_valid = 2'b00;

        // READ_LAT=1 instance
        access(1'b1, 2'b01, 4'h0, 4'h0, 15'h3, 15'h0, 32'h0, 32'h0, w, rd);
        chk("lat1 read", rd, 32'hCAFE_F00D);
        rand_run(1'b1, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
